// File: rtl/bitty_fetch_unit_if.sv
// Instruction-memory and core-side bus of the bitty fetch unit.
// The master side is the fetch unit; the slave side is the memory and the core.
interface bitty_fetch_unit_if #(
  parameter int ADDR_W = 8
) ();
  // instruction memory read channel
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_rdata;
  // core execution channel
  logic [15:0]       d_instr;
  logic              run;
  logic              done;
  logic [15:0]       d_out;

  modport master (
    output mem_req, mem_addr, d_instr, run,
    input  mem_ack, mem_rdata, done, d_out
  );

  modport slave (
    input  mem_req, mem_addr, d_instr, run,
    output mem_ack, mem_rdata, done, d_out
  );
endinterface

// File: rtl/bitty_fetch_unit.sv
// Instruction sequencer for the bitty core: owns the PC, fetches 16-bit words
// over a req/ack handshake, resolves branch and halt words locally and hands
// every other word to the core with run held until done.
module bitty_fetch_unit #(
  parameter int          ADDR_W       = 8,
  parameter int unsigned START_ADDR   = 0,
  parameter int          EXEC_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               halt_req,
  bitty_fetch_unit_if.master bus,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted,
  output logic               error
);

  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);
  localparam int                CNT_W    = (EXEC_TIMEOUT < 2) ? 1 : $clog2(EXEC_TIMEOUT + 1);
  // counter value on which the timeout becomes visible, and the one before it
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(EXEC_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ARM  = CNT_W'(EXEC_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_BRANCH = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic [15:0]       last_result_q, last_result_d;
  logic              error_q, error_d;
  logic              halt_pending_q, halt_pending_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic ack_s;
  logic retire_s;
  logic timeout_s;
  logic stop_s;
  logic start_ok_s;
  logic busy_s;

  // Branch condition on the last core result, read as a signed 16-bit value.
  function automatic logic branch_taken(input logic [1:0] cond, input logic [15:0] val);
    logic taken;
    case (cond)
      2'b00:   taken = (val == 16'h0000);
      2'b01:   taken = ($signed(val) > 16'sd0);
      2'b10:   taken = ($signed(val) < 16'sd0);
      2'b11:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  // Branch target field [11:4], zero-extended or truncated to the PC width.
  function automatic logic [ADDR_W-1:0] branch_target(input logic [15:0] instr);
    logic [31:0] wide;
    wide = {24'h000000, instr[11:4]};
    return wide[ADDR_W-1:0];
  endfunction

  // Events of the current cycle that both next-state and datapath logic use.
  always_comb begin
    busy_s     = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_BRANCH);
    ack_s      = (state_q == S_FETCH) && bus.mem_ack;
    // once the counter hits the limit the timeout wins over a late done
    timeout_s  = (state_q == S_EXEC) && (cnt_q == CNT_LAST);
    retire_s   = (state_q == S_EXEC) && (cnt_q != CNT_LAST) && bus.done;
    // a halt request in the same cycle as the boundary still stops there
    stop_s     = halt_pending_q || halt_req;
    start_ok_s = start && ((state_q == S_IDLE) || (state_q == S_HALT));
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      pc_q           <= START_PC;
      instr_q        <= 16'h0000;
      last_result_q  <= 16'h0000;
      error_q        <= 1'b0;
      halt_pending_q <= 1'b0;
      cnt_q          <= {CNT_W{1'b0}};
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      instr_q        <= instr_d;
      last_result_q  <= last_result_d;
      error_q        <= error_d;
      halt_pending_q <= halt_pending_d;
      cnt_q          <= cnt_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
        else       state_d = S_IDLE;
      end
      S_FETCH: begin
        if (!ack_s)                          state_d = S_FETCH;
        else if (bus.mem_rdata == 16'hFFFF)  state_d = S_HALT;
        else if (bus.mem_rdata[1:0] == 2'b10) state_d = S_BRANCH;
        else                                 state_d = S_EXEC;
      end
      S_EXEC: begin
        if (timeout_s)     state_d = S_HALT;
        else if (retire_s) state_d = stop_s ? S_HALT : S_FETCH;
        else               state_d = S_EXEC;
      end
      S_BRANCH: begin
        state_d = stop_s ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        if (start) state_d = S_FETCH;
        else       state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates: PC, instruction, last result, error, halt request, counter.
  always_comb begin
    pc_d           = pc_q;
    instr_d        = instr_q;
    last_result_d  = last_result_q;
    error_d        = error_q;
    halt_pending_d = halt_pending_q;
    cnt_d          = {CNT_W{1'b0}};

    if (start_ok_s) begin
      pc_d    = START_PC;
      error_d = 1'b0;
    end else if (retire_s) begin
      pc_d = pc_q + 1'b1;
    end else if (state_q == S_BRANCH) begin
      pc_d = branch_taken(instr_q[3:2], last_result_q) ? branch_target(instr_q) : pc_q + 1'b1;
    end else begin
      pc_d = pc_q;
    end

    if (ack_s) instr_d = bus.mem_rdata;
    else       instr_d = instr_q;

    if (start_ok_s && (state_q == S_IDLE)) last_result_d = 16'h0000;
    else if (retire_s)                     last_result_d = bus.d_out;
    else                                   last_result_d = last_result_q;

    // error becomes visible in the cycle the counter reaches the limit
    if ((state_q == S_EXEC) && (cnt_q == CNT_ARM) && !bus.done) error_d = 1'b1;
    else if (start_ok_s)                                        error_d = 1'b0;
    else                                                        error_d = error_q;

    if (start_ok_s)                halt_pending_d = 1'b0;
    else if (state_d == S_HALT)    halt_pending_d = 1'b0;
    else if (busy_s && halt_req)   halt_pending_d = 1'b1;
    else                           halt_pending_d = halt_pending_q;

    if (state_q == S_EXEC) cnt_d = cnt_q + 1'b1;
    else                   cnt_d = {CNT_W{1'b0}};
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    bus.mem_req  = (state_q == S_FETCH);
    bus.mem_addr = pc_q;
    bus.run      = (state_q == S_EXEC);
    bus.d_instr  = instr_q;
    pc           = pc_q;
    busy         = busy_s;
    halted       = (state_q == S_HALT);
    error        = error_q;
  end

endmodule

// File: doc/bitty_fetch_unit.md
# bitty_fetch_unit

Instruction sequencer for the bitty core. It owns the program counter and fetches 16-bit instruction words from an instruction memory over a req/ack handshake. Each non-branch word is presented to the core on `d_instr` with `run` held high until the core's `done`. Branch and halt words are resolved locally and never reach the core. It sits between instruction memory and the core's `d_instr`/`run`/`done`/`d_out` pins, replacing the external instruction driver.

## Interface
- `ADDR_W`, 8: instruction address width. PC arithmetic is modulo 2^ADDR_W.
- `START_ADDR`, 0: PC value loaded on reset and on every `start`.
- `EXEC_TIMEOUT`, 255: maximum cycles in EXEC without `done` before an error halt.
- `clk` in 1: clock clk.
- `reset` in 1: reset reset, asynchronous, active-high.
- `start` in 1: single-cycle pulse; begins execution at `START_ADDR` from IDLE or HALT.
- `halt_req` in 1: request to stop at the next instruction boundary.
- `mem_req` out 1: instruction read request.
- `mem_addr` out ADDR_W: read address; equals `pc`.
- `mem_ack` in 1: read data valid; may assert in the same cycle as `mem_req`.
- `mem_rdata` in 16: instruction word, sampled when `mem_req && mem_ack`.
- `d_instr` out 16: instruction to the core.
- `run` out 1: core enable.
- `done` in 1: core completion.
- `d_out` in 16: core result, sampled with `done`.
- `pc` out ADDR_W: current program counter.
- `busy` out 1: high in FETCH, EXEC, BRANCH.
- `halted` out 1: high in HALT.
- `error` out 1: sticky EXEC timeout flag; cleared by `start` or `reset`.

## Operation
- States are IDLE, FETCH, EXEC, BRANCH, HALT. All outputs are Moore, decoded from state and registers:
  - `mem_req` = FETCH
  - `run` = EXEC
  - `d_instr` = `instr_reg`
- IDLE:
  - `start` → FETCH.
  - Load `pc` = `START_ADDR`, clear `error` and `last_result`.
- FETCH:
  - On `mem_ack`, capture `instr_reg` ← `mem_rdata`, then branch on the word:
    - 16'hFFFF (halt word) → HALT; `pc` unchanged.
    - format `[1:0]` = 2'b10 → BRANCH.
    - Otherwise → EXEC.
  - Without `mem_ack`: stay in FETCH, holding `mem_req` and `mem_addr` stable.
- EXEC:
  - Counter runs from 0; `run` = 1.
  - On `done`: `last_result` ← `d_out`, `pc` ← `pc`+1, leave EXEC.
  - If the counter reaches `EXEC_TIMEOUT` with no `done`: set `error`, → HALT, `pc` unchanged.
- BRANCH (one cycle):
  - Target = `instr_reg[11:4]`, zero-extended or truncated to ADDR_W. Condition = `instr_reg[3:2]`, evaluated on `last_result` as a signed 16-bit value:
    - 00: taken if == 0
    - 01: taken if > 0
    - 10: taken if < 0
    - 11: always taken
  - `pc` ← taken ? target : `pc`+1.
- Leaving EXEC or BRANCH: → HALT if `halt_pending`, else → FETCH.
- `halt_req` sets `halt_pending` in any busy state. `halt_pending` is cleared on entering HALT and on `start`. An in-flight fetch or execution is never aborted.
- HALT: `start` → FETCH with `pc` = `START_ADDR` and `error` cleared. `halt_req` in IDLE or HALT is ignored.
- `start` while busy is ignored.

## Timing
- Reset values:
  - state IDLE
  - `pc` = `mem_addr` = `START_ADDR`
  - `instr_reg` = `d_instr` = 0
  - `last_result` = 0
  - `mem_req`, `run`, `busy`, `halted`, `error` = 0
  - `halt_pending` = 0
- Reset asserted mid-operation forces these values immediately; any outstanding memory ack is discarded.
- Handshake:
  - Transfer happens in a cycle with `mem_req && mem_ack`.
  - `mem_req` deasserts the following cycle.
  - `mem_ack` outside FETCH is ignored.
- `run` rises the cycle after the ack cycle and falls the cycle after `done` is sampled.
- `d_instr` is stable for the whole time `run` is high.
- `done` outside EXEC is ignored.
- Minimum instruction period with zero-wait memory and single-cycle `done`: 2 cycles for ALU/LSU words (FETCH, EXEC), 2 cycles for branches (FETCH, BRANCH).
- PC wraps from 2^ADDR_W−1 to 0.
- `halt_req` and `done` in the same cycle: the instruction retires (`pc`+1), then → HALT.
- Timeout: `error` rises on the cycle the counter equals `EXEC_TIMEOUT`, and `halted` rises the next cycle.

## Test plan
- Reset then `start`, zero-wait memory holding {16'h2021, 16'h0000, 16'hFFFF}, core `done` one cycle after `run`:
  - `pc` sequence 0, 1, 2.
  - `run` high exactly twice.
  - `halted` = 1 with `pc` = 2.
- Memory ack delayed 3 cycles:
  - `mem_req` and `mem_addr` held stable for 3 cycles.
  - `run` rises exactly 1 cycle after ack.
- `d_out` = 16'hFFFE, then branch word cond 10, target 8'h10:
  - `pc` = 8'h10.
  - Same branch after `d_out` = 16'h0005: `pc` = `pc`+1.
- `pc` = 8'hFF, ALU instruction, `done` → `pc` = 8'h00, next fetch address = 0.
- `halt_req` pulsed during EXEC, `done` 4 cycles later:
  - Instruction retires.
  - `halted` = 1, no further `mem_req`.
  - `start` restarts at `START_ADDR`.
- `done` withheld with `EXEC_TIMEOUT` = 255:
  - `error` = 1 after 255 cycles in EXEC, then `halted` = 1.
  - `reset` asserted during EXEC clears everything to reset values in the same cycle.
